// File: rtl/fm_freq_demod.sv
// Purpose: recovers a distance code from the frequency of a square-wave FM input by summing clk cycles over NUM_PERIODS input periods.
// Latency: period_sum updates 1 cycle and distance/valid 3 cycles after the window-closing rising edge is detected (3 clks after fm_in rises).
// Backpressure: none; results are one-cycle valid pulses, enable low aborts the open window, and loss of input edges raises no_signal.
module fm_freq_demod #(
  parameter int WIDTH         = 13,
  parameter int SUM_WIDTH     = 16,
  parameter int NUM_PERIODS   = 64,
  parameter int PERIOD_AT_MIN = 11034,
  parameter int SCALE_NUM     = 180,
  parameter int SCALE_SHIFT   = 6,
  parameter int MAX_DIST      = 2000,
  parameter int TIMEOUT       = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 fm_in,
  output logic [WIDTH-1:0]     distance,
  output logic [SUM_WIDTH-1:0] period_sum,
  output logic                 valid,
  output logic                 no_signal
);
  localparam int PW  = $clog2(NUM_PERIODS);
  localparam int IW  = $clog2(TIMEOUT + 1);
  localparam int KW  = $clog2(SCALE_NUM + 1) + 1;
  localparam int PRW = SUM_WIDTH + 1 + KW;

  localparam logic [SUM_WIDTH-1:0]  CNT_MAX     = '1;
  localparam logic [SUM_WIDTH-1:0]  SUM_AT_MIN  = SUM_WIDTH'(PERIOD_AT_MIN);
  localparam logic [PW-1:0]         LAST_PERIOD = PW'(NUM_PERIODS - 1);
  localparam logic [IW-1:0]         IDLE_LAST   = IW'(TIMEOUT - 1);
  localparam logic [IW-1:0]         IDLE_MAX    = IW'(TIMEOUT);
  localparam logic signed [PRW-1:0] SCALE_X     = PRW'(SCALE_NUM);
  localparam logic signed [PRW-1:0] DIST_MAX_X  = PRW'(MAX_DIST);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t                    state_q, state_d;
  logic                      sync1_q, sync2_q, prev_q, rise;
  logic [SUM_WIDTH-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [PW-1:0]             periods_q, periods_d;
  logic [IW-1:0]             idle_cnt_q, idle_cnt_d;
  logic                      win_close, timeout;

  logic                      s1_vld_q, s2_vld_q, diff_pos_q;
  logic signed [SUM_WIDTH:0] diff_d, diff_q;
  logic signed [PRW-1:0]     prod_d, prod_q, dist_shift;
  logic [WIDTH-1:0]          dist_d, distance_q;
  logic [SUM_WIDTH-1:0]      period_sum_q;
  logic                      valid_q, no_signal_q;

  assign rise    = sync2_q & ~prev_q;
  // Saturating increment: a stuck-low input pins the sum at all-ones, which maps to distance 0.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + SUM_WIDTH'(1);

  // Two-flop synchronizer plus one history flop for rising-edge detection; runs even when disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= fm_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Window FSM and counters: state, cycle sum, period count and cycles since the last edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      periods_q  <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      periods_q  <= periods_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // Next state: count cycles across NUM_PERIODS edges; the closing edge also opens the next window.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    periods_d  = periods_q;
    idle_cnt_d = idle_cnt_q;
    win_close  = 1'b0;
    timeout    = 1'b0;
    if (!enable) begin
      state_d    = IDLE;
      cnt_d      = '0;
      periods_d  = '0;
      idle_cnt_d = '0;
    end else begin
      // An edge in the same cycle as the timeout wins and restarts the idle count.
      if (rise) begin
        idle_cnt_d = '0;
      end else if (idle_cnt_q != IDLE_MAX) begin
        idle_cnt_d = idle_cnt_q + IW'(1);
      end
      timeout = !rise && (idle_cnt_q == IDLE_LAST);
      case (state_q)
        IDLE: begin
          if (rise) begin
            cnt_d     = '0;
            periods_d = '0;
            state_d   = MEASURE;
          end
        end
        MEASURE: begin
          cnt_d = cnt_inc;
          if (rise) begin
            if (periods_q == LAST_PERIOD) begin
              win_close = 1'b1;
              cnt_d     = '0;
              periods_d = '0;
            end else begin
              periods_d = periods_q + PW'(1);
            end
          end else if (timeout) begin
            state_d   = IDLE;
            cnt_d     = '0;
            periods_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign diff_d     = $signed({1'b0, SUM_AT_MIN}) - $signed({1'b0, cnt_inc});
  assign prod_d     = PRW'(diff_q) * SCALE_X;
  assign dist_shift = prod_q >>> SCALE_SHIFT;

  // Final mapping stage: sums at or above the distance-0 sum give 0, large distances clamp.
  always_comb begin
    dist_d = '0;
    if (diff_pos_q) begin
      if (dist_shift > DIST_MAX_X) begin
        dist_d = WIDTH'(MAX_DIST);
      end else begin
        dist_d = WIDTH'(dist_shift);
      end
    end
  end

  // Mapping pipeline (latch sum/diff, multiply, shift+clamp); it drains even if enable drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld_q     <= 1'b0;
      s2_vld_q     <= 1'b0;
      valid_q      <= 1'b0;
      period_sum_q <= '0;
      diff_q       <= '0;
      prod_q       <= '0;
      diff_pos_q   <= 1'b0;
      distance_q   <= '0;
      no_signal_q  <= 1'b1;
    end else begin
      s1_vld_q <= win_close;
      s2_vld_q <= s1_vld_q;
      valid_q  <= s2_vld_q;
      if (win_close) begin
        period_sum_q <= cnt_inc;
        diff_q       <= diff_d;
      end
      if (s1_vld_q) begin
        prod_q     <= prod_d;
        diff_pos_q <= !diff_q[SUM_WIDTH] && (diff_q != '0);
      end
      if (s2_vld_q) begin
        distance_q  <= dist_d;
        no_signal_q <= 1'b0;
      end else if (timeout) begin
        no_signal_q <= 1'b1;
      end
    end
  end

  assign distance   = distance_q;
  assign period_sum = period_sum_q;
  assign valid      = valid_q;
  assign no_signal  = no_signal_q;

endmodule

// File: tb/tb_fm_freq_demod.sv
// Purpose: directed checks of fm_freq_demod against hand-computed window sums and distances.
// Latency: valid expected 3 cycles after the 65th detected rising edge of a fresh lock.
// Backpressure: n/a; square-wave generator is driven on negedges, outputs sampled on negedges.
`timescale 1ns/1ps
module tb_fm_freq_demod;
  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        fm_in;
  logic [12:0] distance;
  logic [15:0] period_sum;
  logic        valid;
  logic        no_signal;

  int  n_cmp = 0;
  int  n_err = 0;

  // Square-wave generator controls: period, high time, running flag.
  bit  gen_on = 1'b0;
  int  gen_p = 172;
  int  gen_hi = 86;
  int  gen_rises = 0;
  int  ph = 0;
  time last_rise_t = 0;

  fm_freq_demod dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .fm_in      (fm_in),
    .distance   (distance),
    .period_sum (period_sum),
    .valid      (valid),
    .no_signal  (no_signal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Waits (bounded) for the next valid pulse; returns cycles waited and no_signal just before it.
  task automatic wait_valid(input string tag, output int ncyc, output logic pns);
    bit seen;
    seen = 1'b0;
    ncyc = 0;
    pns  = no_signal;
    while (!seen && ncyc < 14000) begin
      @(negedge clk);
      ncyc++;
      if (valid === 1'b1) seen = 1'b1;
      else pns = no_signal;
    end
    if (!seen) chk({tag, "_valid_timeout"}, 32'd0, 32'd1);
  endtask

  // Stops the generator, holds enable low long enough to flush the synchronizer, restarts at a new rate.
  task automatic switch_freq(input int p, input int hi, output int r0);
    @(posedge clk);
    #1 gen_on = 1'b0;
    enable = 1'b0;
    repeat (5) @(posedge clk);
    #1 gen_p = p;
    gen_hi = hi;
    enable = 1'b1;
    gen_on = 1'b1;
    r0 = gen_rises;
  endtask

  initial begin
    fm_in = 1'b0;
    forever begin
      @(negedge clk);
      if (gen_on) begin
        if (ph == 0) begin
          fm_in = 1'b1;
          gen_rises++;
          last_rise_t = $time;
        end else if (ph == gen_hi) begin
          fm_in = 1'b0;
        end
        ph = (ph == gen_p - 1) ? 0 : ph + 1;
      end else begin
        fm_in = 1'b0;
        ph = 0;
      end
    end
  end

  initial begin
    int   nc, x, r0, elapsed;
    logic pns;
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_distance",   distance,   0);
    chk("rst_period_sum", period_sum, 0);
    chk("rst_valid",      valid,      0);
    chk("rst_no_signal",  no_signal,  1);
    #2 reset = 1'b0;
    enable = 1'b1;
    @(posedge clk);
    #1 gen_on = 1'b1;
    r0 = gen_rises;

    // P=172: 64*172 = 11008, (11034-11008)*180 >> 6 = 73.
    wait_valid("p172_first", nc, pns);
    chk("p172_rises_to_first_valid", gen_rises - r0, 65);
    chk("p172_period_sum",           period_sum, 11008);
    chk("p172_distance",             distance,   73);
    chk("p172_no_signal_at_valid",   no_signal,  0);
    chk("p172_no_signal_before",     pns,        1);
    wait_valid("p172_second", nc, pns);
    chk("p172_valid_interval",  nc,         11008);
    chk("p172_period_sum_2",    period_sum, 11008);
    x = gen_rises;
    @(negedge clk);
    chk("valid_one_cycle", valid, 0);

    // Drop enable for 500 cycles a few periods into a window; re-enable with fm_in low.
    for (int i = 0; i < 2000 && gen_rises < x + 3; i++) @(posedge clk);
    #1 enable = 1'b0;
    repeat (500) @(posedge clk);
    for (int i = 0; i < 400 && fm_in !== 1'b0; i++) @(posedge clk);
    #1 enable = 1'b1;
    r0 = gen_rises;
    wait_valid("en", nc, pns);
    chk("en_rises_to_valid", gen_rises - r0, 65);
    chk("en_period_sum",     period_sum, 11008);
    chk("en_distance",       distance,   73);

    // Reset mid-cycle during the 30th period of a window; resume at P=161 afterwards.
    x = gen_rises;
    for (int i = 0; i < 8000 && gen_rises < x + 29; i++) @(posedge clk);
    repeat (20) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("midrst_distance",   distance,   0);
    chk("midrst_period_sum", period_sum, 0);
    chk("midrst_valid",      valid,      0);
    chk("midrst_no_signal",  no_signal,  1);
    gen_on = 1'b0;
    gen_p  = 161;
    gen_hi = 80;
    repeat (5) @(posedge clk);
    #3 reset = 1'b0;
    gen_on = 1'b1;
    r0 = gen_rises;
    // P=161: sum 10304, raw (730*180)>>6 = 2053 clamps to 2000.
    wait_valid("p161", nc, pns);
    chk("p161_rises_to_valid",   gen_rises - r0, 65);
    chk("p161_no_signal_before", pns,        1);
    chk("p161_period_sum",       period_sum, 10304);
    chk("p161_distance_clamp",   distance,   2000);

    // P=180: sum 11520 exceeds the distance-0 sum, so distance is 0.
    switch_freq(180, 90, r0);
    wait_valid("p180", nc, pns);
    chk("p180_rises_to_valid", gen_rises - r0, 65);
    chk("p180_period_sum",     period_sum, 11520);
    chk("p180_distance_zero",  distance,   0);

    // P=170 with one-cycle-high pulses: sum 10880, (154*180)>>6 = 433.
    switch_freq(170, 1, r0);
    wait_valid("p170", nc, pns);
    chk("p170_rises_to_valid", gen_rises - r0, 65);
    chk("p170_period_sum",     period_sum, 10880);
    chk("p170_distance",       distance,   433);

    // Stop toggling: fm_in rise to registered edge is 3 clks, then TIMEOUT more to no_signal.
    @(posedge clk);
    #1 gen_on = 1'b0;
    elapsed = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (no_signal === 1'b1) begin
        elapsed = int'(($time - last_rise_t) / 10);
        break;
      end
    end
    chk("timeout_cycles_after_last_edge", elapsed, 3 + 1024);
    chk("timeout_distance_hold",   distance,   433);
    chk("timeout_period_sum_hold", period_sum, 10880);

    // Restart at P=166: sum 10624, (410*180)>>6 = 1153; no_signal falls with valid.
    @(posedge clk);
    #1 gen_p = 166;
    gen_hi = 83;
    gen_on = 1'b1;
    r0 = gen_rises;
    wait_valid("restart", nc, pns);
    chk("restart_rises_to_valid",   gen_rises - r0, 65);
    chk("restart_no_signal_before", pns,        1);
    chk("restart_no_signal_at",     no_signal,  0);
    chk("restart_period_sum",       period_sum, 10624);
    chk("restart_distance",         distance,   1153);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
